// File: rtl/dbus_cbus_bridge.sv
// Bridges the Memory-stage dbus handshake onto a single-beat, single-outstanding cbus access.
// The request is latched on acceptance; the response is optionally registered (REG_RESP).
module dbus_cbus_bridge #(
    parameter bit REG_RESP = 1'b0
) (
    input  logic        i_clk,
    input  logic        i_resetn,
    input  logic        i_dreq_valid,
    input  logic [31:0] i_dreq_addr,
    input  logic [2:0]  i_dreq_size,
    input  logic [3:0]  i_dreq_strobe,
    input  logic [31:0] i_dreq_data,
    output logic        o_dresp_addr_ok,
    output logic        o_dresp_data_ok,
    output logic [31:0] o_dresp_data,
    output logic        o_creq_valid,
    output logic        o_creq_is_write,
    output logic [2:0]  o_creq_size,
    output logic [31:0] o_creq_addr,
    output logic [3:0]  o_creq_strobe,
    output logic [31:0] o_creq_data,
    output logic [3:0]  o_creq_len,
    input  logic        i_cresp_ready,
    input  logic        i_cresp_last,
    input  logic [31:0] i_cresp_data
);

    typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

    state_e      r_state;
    state_e      w_state_next;
    logic        w_accept;
    logic        w_beat;

    logic [31:0] r_addr;
    logic [2:0]  r_size;
    logic [3:0]  r_strobe;
    logic [31:0] r_data;
    logic        r_is_write;
    logic [31:0] r_resp_data;

    assign w_accept = i_dreq_valid && (r_state == StIdle);
    // A ready beat without last is a protocol violation and is ignored.
    assign w_beat   = (r_state == StBusy) && i_cresp_ready && i_cresp_last;

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: if (i_dreq_valid) w_state_next = StBusy;
            StBusy: if (w_beat)       w_state_next = REG_RESP ? StResp : StIdle;
            StResp:                   w_state_next = StIdle;
            default:                  w_state_next = StIdle;
        endcase
    end

    always_comb begin
        o_dresp_addr_ok = w_accept;
        o_creq_valid    = (r_state == StBusy);
        if (REG_RESP) begin
            o_dresp_data_ok = (r_state == StResp);
            o_dresp_data    = r_resp_data;
        end else begin
            o_dresp_data_ok = w_beat;
            o_dresp_data    = i_resetn ? i_cresp_data : 32'h0;
        end
    end

    // Request latch: cbus side never sees dreq_* directly.
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_addr     <= 32'h0;
            r_size     <= 3'h0;
            r_strobe   <= 4'h0;
            r_data     <= 32'h0;
            r_is_write <= 1'b0;
        end else if (w_accept) begin
            r_addr     <= i_dreq_addr;
            r_size     <= i_dreq_size;
            r_strobe   <= i_dreq_strobe;
            r_data     <= i_dreq_data;
            r_is_write <= |i_dreq_strobe;
        end
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_resp_data <= 32'h0;
        end else if (REG_RESP && w_beat) begin
            r_resp_data <= i_cresp_data;
        end
    end

    assign o_creq_is_write = r_is_write;
    assign o_creq_size     = r_size;
    assign o_creq_addr     = r_addr;
    assign o_creq_strobe   = r_strobe;
    assign o_creq_data     = r_data;
    assign o_creq_len      = 4'h0;

endmodule

// File: tb/tb_dbus_cbus_bridge.sv
// Bench for dbus_cbus_bridge: one instance per REG_RESP setting, a transaction-level model
// checked every cycle, and directed sequences with literal expectations.
module tb_dbus_cbus_bridge;

    logic        clk = 1'b0;
    logic        resetn;

    logic        dreq_valid    [2];
    logic [31:0] dreq_addr     [2];
    logic [2:0]  dreq_size     [2];
    logic [3:0]  dreq_strobe   [2];
    logic [31:0] dreq_data     [2];
    logic        addr_ok       [2];
    logic        data_ok       [2];
    logic [31:0] dresp_data    [2];
    logic        creq_valid    [2];
    logic        creq_is_write [2];
    logic [2:0]  creq_size     [2];
    logic [31:0] creq_addr     [2];
    logic [3:0]  creq_strobe   [2];
    logic [31:0] creq_data     [2];
    logic [3:0]  creq_len      [2];
    logic        cresp_ready   [2];
    logic        cresp_last    [2];
    logic [31:0] cresp_data    [2];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_inst
        dbus_cbus_bridge #(
            .REG_RESP(g == 1)
        ) u_dut (
            .i_clk           (clk),
            .i_resetn        (resetn),
            .i_dreq_valid    (dreq_valid[g]),
            .i_dreq_addr     (dreq_addr[g]),
            .i_dreq_size     (dreq_size[g]),
            .i_dreq_strobe   (dreq_strobe[g]),
            .i_dreq_data     (dreq_data[g]),
            .o_dresp_addr_ok (addr_ok[g]),
            .o_dresp_data_ok (data_ok[g]),
            .o_dresp_data    (dresp_data[g]),
            .o_creq_valid    (creq_valid[g]),
            .o_creq_is_write (creq_is_write[g]),
            .o_creq_size     (creq_size[g]),
            .o_creq_addr     (creq_addr[g]),
            .o_creq_strobe   (creq_strobe[g]),
            .o_creq_data     (creq_data[g]),
            .o_creq_len      (creq_len[g]),
            .i_cresp_ready   (cresp_ready[g]),
            .i_cresp_last    (cresp_last[g]),
            .i_cresp_data    (cresp_data[g])
        );

        // Transaction-level model: an in-flight request and an optional pending response.
        logic        m_busy  = 1'b0;
        logic        m_resp  = 1'b0;
        logic [31:0] m_addr  = 32'h0;
        logic [2:0]  m_size  = 3'h0;
        logic [3:0]  m_strb  = 4'h0;
        logic [31:0] m_data  = 32'h0;
        logic [31:0] m_rdata = 32'h0;

        wire e_aok  = dreq_valid[g] && !m_busy && !m_resp;
        wire e_beat = m_busy && cresp_ready[g] && cresp_last[g];
        wire e_dok  = (g == 1) ? m_resp : e_beat;
        wire [31:0] e_rdata = (g == 1) ? m_rdata : cresp_data[g];

        always @(negedge clk) begin
            if (!resetn) begin
                chk($sformatf("u%0d.rst.addr_ok", g), addr_ok[g], 0);
                chk($sformatf("u%0d.rst.data_ok", g), data_ok[g], 0);
                chk($sformatf("u%0d.rst.creq_valid", g), creq_valid[g], 0);
                chk($sformatf("u%0d.rst.dresp_data", g), dresp_data[g], 0);
                m_busy  <= 1'b0;
                m_resp  <= 1'b0;
                m_rdata <= 32'h0;
            end else begin
                chk($sformatf("u%0d.addr_ok", g), addr_ok[g], e_aok);
                chk($sformatf("u%0d.data_ok", g), data_ok[g], e_dok);
                chk($sformatf("u%0d.creq_valid", g), creq_valid[g], m_busy);
                chk($sformatf("u%0d.creq_len", g), creq_len[g], 0);
                chk($sformatf("u%0d.dresp_data", g), dresp_data[g], e_rdata);
                if (m_busy) begin
                    chk($sformatf("u%0d.creq_addr", g), creq_addr[g], m_addr);
                    chk($sformatf("u%0d.creq_size", g), creq_size[g], m_size);
                    chk($sformatf("u%0d.creq_strobe", g), creq_strobe[g], m_strb);
                    chk($sformatf("u%0d.creq_data", g), creq_data[g], m_data);
                    chk($sformatf("u%0d.creq_is_write", g), creq_is_write[g], |m_strb);
                end
                if (m_resp) m_resp <= 1'b0;
                if (e_beat) begin
                    m_busy <= 1'b0;
                    if (g == 1) begin
                        m_resp  <= 1'b1;
                        m_rdata <= cresp_data[g];
                    end
                end
                if (e_aok) begin
                    m_busy <= 1'b1;
                    m_addr <= dreq_addr[g];
                    m_size <= dreq_size[g];
                    m_strb <= dreq_strobe[g];
                    m_data <= dreq_data[g];
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    task automatic req(input int k, input logic [31:0] a, input logic [2:0] s,
                       input logic [3:0] st, input logic [31:0] d);
        dreq_valid[k]  = 1'b1;
        dreq_addr[k]   = a;
        dreq_size[k]   = s;
        dreq_strobe[k] = st;
        dreq_data[k]   = d;
    endtask

    task automatic beat(input int k, input logic [31:0] d);
        cresp_ready[k] = 1'b1;
        cresp_last[k]  = 1'b1;
        cresp_data[k]  = d;
    endtask

    task automatic quiet(input int k);
        cresp_ready[k] = 1'b0;
        cresp_last[k]  = 1'b0;
        cresp_data[k]  = 32'h0;
    endtask

    initial begin
        resetn = 1'b0;
        for (int k = 0; k < 2; k++) begin
            req(k, 32'h0, 3'h0, 4'h0, 32'h0);
            dreq_valid[k] = 1'b0;
            quiet(k);
        end
        repeat (2) neg();
        chk("reset.creq_valid", creq_valid[1], 0);
        chk("reset.dresp_data", dresp_data[1], 0);
        tick();
        resetn = 1'b1;

        // Load, REG_RESP=0
        tick();
        req(0, 32'h8000_0104, 3'd2, 4'h0, 32'h0);
        neg();
        chk("load.addr_ok", addr_ok[0], 1);
        chk("load.creq_valid_idle", creq_valid[0], 0);
        tick();
        dreq_valid[0] = 1'b0;
        neg();
        chk("load.creq_valid", creq_valid[0], 1);
        chk("load.is_write", creq_is_write[0], 0);
        chk("load.creq_addr", creq_addr[0], 32'h8000_0104);
        chk("load.creq_len", creq_len[0], 0);
        tick();
        neg();
        chk("load.wait_data_ok", data_ok[0], 0);
        tick();
        beat(0, 32'hDEAD_BEEF);
        neg();
        chk("load.data_ok", data_ok[0], 1);
        chk("load.dresp_data", dresp_data[0], 32'hDEAD_BEEF);
        tick();
        quiet(0);
        neg();
        chk("load.idle_after", creq_valid[0], 0);

        // Store with withdrawn request
        tick();
        req(0, 32'h8000_0002, 3'd1, 4'b1100, 32'hABCD_0000);
        neg();
        chk("store.addr_ok", addr_ok[0], 1);
        tick();
        dreq_valid[0] = 1'b0;
        dreq_addr[0]  = 32'h0;
        neg();
        chk("store.creq_addr", creq_addr[0], 32'h8000_0002);
        chk("store.creq_strobe", creq_strobe[0], 4'b1100);
        chk("store.is_write", creq_is_write[0], 1);
        chk("store.creq_data", creq_data[0], 32'hABCD_0000);
        tick();
        beat(0, 32'h0);
        neg();
        chk("store.data_ok", data_ok[0], 1);
        tick();
        quiet(0);

        // Protocol violation: ready without last
        req(0, 32'h8000_0010, 3'd2, 4'h0, 32'h0);
        neg();
        chk("viol.addr_ok", addr_ok[0], 1);
        tick();
        dreq_valid[0]  = 1'b0;
        cresp_ready[0] = 1'b1;
        cresp_last[0]  = 1'b0;
        cresp_data[0]  = 32'h5555_5555;
        neg();
        chk("viol.data_ok", data_ok[0], 0);
        chk("viol.creq_valid", creq_valid[0], 1);
        tick();
        beat(0, 32'h1111_2222);
        neg();
        chk("viol.final_data", dresp_data[0], 32'h1111_2222);
        tick();
        quiet(0);

        // Back-to-back with dreq_valid held
        req(0, 32'h8000_0020, 3'd2, 4'h0, 32'h0);
        neg();
        chk("b2b.addr_ok1", addr_ok[0], 1);
        tick();
        dreq_addr[0] = 32'h8000_0024;
        neg();
        chk("b2b.busy_addr_ok", addr_ok[0], 0);
        tick();
        beat(0, 32'hA1A1_A1A1);
        neg();
        chk("b2b.data_ok1", data_ok[0], 1);
        chk("b2b.no_overlap", addr_ok[0], 0);
        tick();
        quiet(0);
        neg();
        chk("b2b.addr_ok2", addr_ok[0], 1);
        tick();
        dreq_valid[0] = 1'b0;
        neg();
        chk("b2b.creq_addr2", creq_addr[0], 32'h8000_0024);
        tick();
        beat(0, 32'hA2A2_A2A2);
        neg();
        chk("b2b.data_ok2", data_ok[0], 1);
        tick();
        quiet(0);

        // REG_RESP=1
        req(1, 32'h8000_0104, 3'd2, 4'h0, 32'h0);
        neg();
        chk("reg.addr_ok", addr_ok[1], 1);
        tick();
        dreq_valid[1] = 1'b0;
        beat(1, 32'h1234_5678);
        neg();
        chk("reg.beat_data_ok", data_ok[1], 0);
        tick();
        quiet(1);
        req(1, 32'h8000_0200, 3'd2, 4'h0, 32'h0);
        neg();
        chk("reg.data_ok", data_ok[1], 1);
        chk("reg.dresp_data", dresp_data[1], 32'h1234_5678);
        chk("reg.resp_addr_ok", addr_ok[1], 0);
        tick();
        neg();
        chk("reg.addr_ok2", addr_ok[1], 1);
        chk("reg.hold_data", dresp_data[1], 32'h1234_5678);
        tick();
        dreq_valid[1] = 1'b0;
        beat(1, 32'hCAFE_F00D);
        neg();
        tick();
        quiet(1);
        neg();
        chk("reg.dresp_data2", dresp_data[1], 32'hCAFE_F00D);
        tick();

        // Reset mid-transaction on both instances
        req(0, 32'h8000_0300, 3'd2, 4'h0, 32'h0);
        req(1, 32'h8000_0304, 3'd2, 4'h0, 32'h0);
        neg();
        tick();
        dreq_valid[0] = 1'b0;
        dreq_valid[1] = 1'b0;
        neg();
        chk("rst_mid.busy0", creq_valid[0], 1);
        tick();
        resetn = 1'b0;
        #1;
        chk("rst_mid.creq_valid0", creq_valid[0], 0);
        chk("rst_mid.creq_valid1", creq_valid[1], 0);
        neg();
        tick();
        resetn = 1'b1;
        beat(0, 32'h7777_7777);
        beat(1, 32'h8888_8888);
        neg();
        chk("rst_mid.stray0", data_ok[0], 0);
        chk("rst_mid.stray1", data_ok[1], 0);
        tick();
        quiet(0);
        quiet(1);
        neg();
        chk("rst_mid.late1", data_ok[1], 0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
